// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the up/down counter family: FSM encoding and common widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package down_counter_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int UP_CNT_WIDTH = 4;
    localparam int DN_CNT_WIDTH = 4;

    // A divide-by-1 prescaler still needs a legal 1-bit vector width.
    function automatic int prescale_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/down_counter_timer_tick_prescaler.sv
// Tick prescaler: emits one tick every PRESCALE enabled cycles.
// Latency: combinational tick from the registered phase counter; PRESCALE=1 is a wire.
// Backpressure: none; en low freezes the phase, clr restarts it.
module tick_prescaler
    import down_counter_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            logic unused_ok;
            assign unused_ok = ^{clk, rst, clr};
            assign tick      = en;
        end else begin : g_div
            localparam int            PW   = prescale_width(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] phase;

            assign tick = en && (phase == LAST);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    phase <= '0;
                end else if (clr || tick) begin
                    phase <= '0;
                end else if (en) begin
                    phase <= phase + PW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes and a 1-cycle tc pulse.
// Latency: count valid the edge after start; tc registered, one cycle after the tick at zero.
// Backpressure: none; en low holds count, prescaler and state.
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH    = DN_CNT_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             stop,
    input  logic             en,
    input  logic             auto_rld,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             run;
    logic             tick;
    logic             at_zero;

    assign run     = (state == ST_RUN);
    assign at_zero = (count == '0);

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (start || stop || !run),
        .en  (run && en),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // start outranks stop, which outranks a pending tick.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_RUN;
        end else if (stop) begin
            state_nxt = ST_IDLE;
        end else if (tick && at_zero && !auto_rld) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        busy = (state == ST_RUN);
    end

    // Terminal count saturates at zero: reload or park, never wrap.
    always_comb begin
        count_nxt  = count;
        reload_nxt = reload;
        tc_nxt     = 1'b0;
        if (start) begin
            count_nxt  = load_val;
            reload_nxt = load_val;
        end else if (stop) begin
            count_nxt = count;
        end else if (tick) begin
            if (!at_zero) begin
                count_nxt = count - WIDTH'(1);
            end else begin
                tc_nxt = 1'b1;
                if (auto_rld) begin
                    count_nxt = reload;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            reload <= '0;
            tc     <= 1'b0;
        end else begin
            count  <= count_nxt;
            reload <= reload_nxt;
            tc     <= tc_nxt;
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: vector table for the single-cycle behaviour,
// hand sequences for full-range countdown, prescaled timing and asynchronous reset.
module tb_down_counter_timer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       en;
    logic       auto_rld;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       tc;
    logic       busy;

    logic       p_start;
    logic       p_en;
    logic [3:0] p_load_val;
    logic [3:0] p_count;
    logic       p_tc;
    logic       p_busy;

    int tests_run;
    int tests_failed;

    down_counter_timer #(.WIDTH(4), .PRESCALE(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .load_val(load_val),
        .stop    (stop),
        .en      (en),
        .auto_rld(auto_rld),
        .count   (count),
        .tc      (tc),
        .busy    (busy)
    );

    down_counter_timer #(.WIDTH(4), .PRESCALE(3)) dut_p (
        .clk     (clk),
        .rst     (rst),
        .start   (p_start),
        .load_val(p_load_val),
        .stop    (1'b0),
        .en      (p_en),
        .auto_rld(1'b0),
        .count   (p_count),
        .tc      (p_tc),
        .busy    (p_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       start;
        logic       stop;
        logic       en;
        logic       arl;
        logic [3:0] lv;
        logic [3:0] exp_count;
        logic       exp_tc;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic s, input logic sp, input logic e, input logic a,
                               input logic [3:0] lv, input logic [3:0] ec,
                               input logic et, input logic eb);
        vec_t r;
        r.start = s;  r.stop = sp; r.en = e; r.arl = a; r.lv = lv;
        r.exp_count = ec; r.exp_tc = et; r.exp_busy = eb;
        return r;
    endfunction

    task automatic check(input string name,
                         input logic [3:0] act_c, input logic act_t, input logic act_b,
                         input logic [3:0] exp_c, input logic exp_t, input logic exp_b);
        tests_run++;
        if (act_c !== exp_c || act_t !== exp_t || act_b !== exp_b) begin
            tests_failed++;
            $display("FAIL %s: got count=%0d tc=%0b busy=%0b, expected count=%0d tc=%0b busy=%0b",
                     name, act_c, act_t, act_b, exp_c, exp_t, exp_b);
        end
    endtask

    task automatic drive(input logic s, input logic sp, input logic e, input logic a,
                         input logic [3:0] lv);
        start = s; stop = sp; en = e; auto_rld = a; load_val = lv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b0;
        drive(0, 0, 0, 0, 4'd0);
        p_start = 1'b0; p_en = 1'b0; p_load_val = 4'd0;

        // Reset asserted between edges, held across the first edge.
        #1 rst = 1'b1;
        #2 check("reset_async", count, tc, busy, 4'd0, 1'b0, 1'b0);
        step();
        check("reset_held", count, tc, busy, 4'd0, 1'b0, 1'b0);
        check("reset_p", p_count, p_tc, p_busy, 4'd0, 1'b0, 1'b0);
        #5 rst = 1'b0;

        // start, stop, en, auto_rld, load_val -> count, tc, busy
        vecs.push_back(v(1,0,1,0,4'd3, 4'd3,0,1));
        vecs.push_back(v(0,0,1,0,4'd0, 4'd2,0,1));
        vecs.push_back(v(0,0,1,0,4'd0, 4'd1,0,1));
        vecs.push_back(v(0,0,1,0,4'd0, 4'd0,0,1));
        vecs.push_back(v(0,0,1,0,4'd0, 4'd0,1,0));
        vecs.push_back(v(0,0,1,0,4'd0, 4'd0,0,0));
        vecs.push_back(v(1,0,1,1,4'd2, 4'd2,0,1));
        vecs.push_back(v(0,0,1,1,4'd0, 4'd1,0,1));
        vecs.push_back(v(0,0,1,1,4'd0, 4'd0,0,1));
        vecs.push_back(v(0,0,1,1,4'd0, 4'd2,1,1));
        vecs.push_back(v(0,0,1,1,4'd0, 4'd1,0,1));
        vecs.push_back(v(0,0,1,1,4'd0, 4'd0,0,1));
        vecs.push_back(v(0,0,1,1,4'd0, 4'd2,1,1));
        vecs.push_back(v(1,0,1,0,4'd5, 4'd5,0,1));
        vecs.push_back(v(0,0,1,0,4'd0, 4'd4,0,1));
        vecs.push_back(v(0,0,0,0,4'd0, 4'd4,0,1));
        vecs.push_back(v(0,0,1,0,4'd0, 4'd3,0,1));
        vecs.push_back(v(0,0,0,0,4'd0, 4'd3,0,1));
        vecs.push_back(v(0,0,1,0,4'd0, 4'd2,0,1));
        vecs.push_back(v(0,1,1,0,4'd0, 4'd2,0,0));
        vecs.push_back(v(0,0,1,0,4'd0, 4'd2,0,0));
        vecs.push_back(v(1,0,1,0,4'd5, 4'd5,0,1));
        vecs.push_back(v(0,0,1,0,4'd0, 4'd4,0,1));
        vecs.push_back(v(0,0,1,0,4'd0, 4'd3,0,1));
        vecs.push_back(v(0,0,1,0,4'd0, 4'd2,0,1));
        vecs.push_back(v(1,0,1,0,4'd9, 4'd9,0,1));
        vecs.push_back(v(0,0,1,0,4'd0, 4'd8,0,1));
        vecs.push_back(v(1,1,1,0,4'd4, 4'd4,0,1));
        vecs.push_back(v(0,0,1,0,4'd0, 4'd3,0,1));
        vecs.push_back(v(0,1,1,0,4'd0, 4'd3,0,0));
        vecs.push_back(v(1,0,0,0,4'd0, 4'd0,0,1));
        vecs.push_back(v(0,0,0,0,4'd0, 4'd0,0,1));
        vecs.push_back(v(0,0,1,0,4'd0, 4'd0,1,0));
        vecs.push_back(v(0,0,1,0,4'd0, 4'd0,0,0));
        vecs.push_back(v(1,0,1,1,4'd0, 4'd0,0,1));
        vecs.push_back(v(0,0,1,1,4'd0, 4'd0,1,1));
        vecs.push_back(v(0,0,1,1,4'd0, 4'd0,1,1));
        vecs.push_back(v(0,0,0,1,4'd0, 4'd0,0,1));
        vecs.push_back(v(0,1,1,1,4'd0, 4'd0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].en, vecs[i].arl, vecs[i].lv);
            step();
            check($sformatf("vec%0d", i), count, tc, busy,
                  vecs[i].exp_count, vecs[i].exp_tc, vecs[i].exp_busy);
        end

        // Full-range load: 16 ticks to tc, saturating at zero.
        drive(1, 0, 1, 0, 4'd15);
        step();
        check("lv15_load", count, tc, busy, 4'd15, 1'b0, 1'b1);
        drive(0, 0, 1, 0, 4'd0);
        for (int k = 14; k >= 0; k--) begin
            step();
            check($sformatf("lv15_cnt%0d", k), count, tc, busy, 4'(k), 1'b0, 1'b1);
        end
        step();
        check("lv15_tc", count, tc, busy, 4'd0, 1'b1, 1'b0);
        step();
        check("lv15_nowrap", count, tc, busy, 4'd0, 1'b0, 1'b0);

        // PRESCALE=3, load 1: count drops on the 3rd enabled cycle, tc after the 6th.
        p_start = 1'b1; p_en = 1'b1; p_load_val = 4'd1;
        step();
        check("psc_load", p_count, p_tc, p_busy, 4'd1, 1'b0, 1'b1);
        p_start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("psc_cyc%0d", k), p_count, p_tc, p_busy,
                  (k < 3) ? 4'd1 : 4'd0, (k == 6), (k < 6));
        end
        step();
        check("psc_after", p_count, p_tc, p_busy, 4'd0, 1'b0, 1'b0);
        p_en = 1'b0;

        // Asynchronous reset mid-run with a nonzero count.
        drive(1, 0, 1, 0, 4'd9);
        step();
        drive(0, 0, 1, 0, 4'd0);
        step();
        check("rst_pre", count, tc, busy, 4'd8, 1'b0, 1'b1);
        #3 rst = 1'b1;
        #1 check("rst_mid_now", count, tc, busy, 4'd0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        check("rst_mid_held", count, tc, busy, 4'd0, 1'b0, 1'b0);

        // Reset landing just before the edge that would emit tc suppresses it.
        drive(1, 0, 1, 0, 4'd1);
        step();
        drive(0, 0, 1, 0, 4'd0);
        step();
        check("rst_tc_pre", count, tc, busy, 4'd0, 1'b0, 1'b1);
        #3 rst = 1'b1;
        step();
        check("rst_tc_blocked", count, tc, busy, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check("rst_tc_idle", count, tc, busy, 4'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
